// File: rtl/imem_axi_read_slave.sv
// Instruction-memory AXI3 read-only slave: one outstanding burst, one synchronous
// array read per beat, plus a backdoor word-write port for program preload.
module imem_axi_read_slave #(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ARADDR,
  input  logic [3:0]  ARLEN,
  input  logic [1:0]  ARBURST,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, FETCH, BEAT} state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [31:0] mem [MEM_WORDS];

  logic        addr_in_range;
  logic        load_in_range;
  logic        burst_err;
  logic [29:0] wrap_mask;
  logic [29:0] addr_next;
  logic        unused_ok;

  assign unused_ok = ^{ARADDR[1:0], load_addr[1:0]};

  assign addr_in_range = (32'(addr_q) < 32'(MEM_WORDS));
  assign load_in_range = (32'(load_addr[31:2]) < 32'(MEM_WORDS));

  // A WRAP burst is only legal for 2, 4, 8 or 16 beats; 11 is reserved.
  assign burst_err = (burst_q == 2'b11) ||
                     ((burst_q == 2'b10) &&
                      !((len_q == 4'd1) || (len_q == 4'd3) ||
                        (len_q == 4'd7) || (len_q == 4'd15)));

  assign wrap_mask = {26'd0, len_q};

  always_comb begin
    addr_next = addr_q;
    case (burst_q)
      2'b01:   addr_next = addr_q + 30'd1;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | ((addr_q + 30'd1) & wrap_mask);
      default: addr_next = addr_q;
    endcase
  end

  // Backdoor preload; no reset so program contents survive rst.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      mem[load_addr[AW+1:2]] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (state_q)
      IDLE: begin
        if (ARVALID) begin
          addr_d     = ARADDR[31:2];
          len_d      = ARLEN;
          burst_d    = ARBURST;
          beat_cnt_d = ARLEN;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // Reads the array before this edge's load lands, so a colliding load is not seen.
        if (burst_err || !addr_in_range) begin
          rdata_d = '0;
          rresp_d = 2'b10;
        end else begin
          rdata_d = mem[addr_q[AW-1:0]];
          rresp_d = 2'b00;
        end
        state_d = BEAT;
      end
      BEAT: begin
        if (RREADY) begin
          if (beat_cnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - 4'd1;
            addr_d     = addr_next;
            state_d    = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (state_q == IDLE);
    RVALID  = (state_q == BEAT);
    RLAST   = (state_q == BEAT) && (beat_cnt_q == 4'd0);
    RDATA   = rdata_q;
    RRESP   = rresp_q;
  end

endmodule

// File: tb/tb_imem_axi_read_slave.sv
// Scoreboard bench: directed bursts push expected beats; a negedge monitor pops and
// compares data, response, last flag and (where fixed) the cycle of each beat.
module tb_imem_axi_read_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  imem_axi_read_slave #(.MEM_WORDS(4096)) dut (
    .clk(clk), .rst(rst),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] exp_words[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && RVALID && RREADY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got data %h with empty scoreboard", RDATA);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data", RDATA, e.data);
        chk("beat_resp", 32'(RRESP), 32'(e.resp));
        chk("beat_last", 32'(RLAST), 32'(e.last));
        if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic [1:0] r, input logic l, input int c);
    beat_t e;
    e.data = d; e.resp = r; e.last = l; e.cyc = c;
    sb.push_back(e);
  endtask

  // Beats of a never-stalled burst appear at T+2, T+4, ...
  task automatic push_burst(input int t, input logic [1:0] r);
    for (int i = 0; i < exp_words.size(); i++)
      push(exp_words[i], r, (i == exp_words.size() - 1), t + 2 + 2 * i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Returns t, the cycle in which ARVALID is presented while ARREADY=1.
  task automatic ar_req(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                        output int t);
    int n;
    n = 0;
    while (!ARREADY && n < 100) begin step(); n++; end
    if (!ARREADY) chk("arready_timeout", 32'(ARREADY), 32'd1);
    ARADDR = a; ARLEN = l; ARBURST = b; ARVALID = 1'b1;
    t = cyc;
    step();
    ARVALID = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(sb.size() == 0 && ARREADY) && n < 300) begin step(); n++; end
    chk("burst_done", 32'(sb.size() == 0 && ARREADY), 32'd1);
  endtask

  int t;
  int m;

  initial begin
    #3;
    chk("rst_arready", 32'(ARREADY), 32'd1);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rlast", 32'(RLAST), 32'd0);
    chk("rst_rresp", 32'(RRESP), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) load(32'(i * 4), 32'h100 + 32'(i));
    load(32'h3FFC, 32'hABCD_0FFF);
    load(32'h4000, 32'hBAD0_BAD0);

    exp_words = '{32'h100, 32'h101, 32'h102, 32'h103};
    ar_req(32'h0, 4'd3, 2'b01, t); push_burst(t, 2'b00); wait_done();

    exp_words = '{32'h106, 32'h107, 32'h104, 32'h105};
    ar_req(32'h18, 4'd3, 2'b10, t); push_burst(t, 2'b00); wait_done();

    // Stall beat 0 for 5 cycles; a stray ARVALID meanwhile must be ignored.
    RREADY = 1'b0;
    ar_req(32'h0, 4'd1, 2'b01, t);
    push(32'h100, 2'b00, 1'b0, -1);
    m = 0;
    while (!RVALID && m < 20) begin step(); m++; end
    ARADDR = 32'h40; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", 32'(RVALID), 32'd1);
      chk("stall_rdata", RDATA, 32'h100);
      chk("stall_rlast", 32'(RLAST), 32'd0);
      chk("stall_arready", 32'(ARREADY), 32'd0);
      step();
    end
    ARVALID = 1'b0;
    m = cyc;
    push(32'h101, 2'b00, 1'b1, m + 2);
    RREADY = 1'b1;
    wait_done();

    exp_words = '{32'hABCD_0FFF};
    ar_req(32'h3FFC, 4'd1, 2'b01, t);
    push_burst(t, 2'b00);
    push(32'h0, 2'b10, 1'b1, t + 4);
    sb[0].last = 1'b0;
    wait_done();

    exp_words = '{32'h103, 32'h103, 32'h103};
    ar_req(32'h0D, 4'd2, 2'b00, t); push_burst(t, 2'b00); wait_done();

    ar_req(32'hFFFF_FFFC, 4'd1, 2'b01, t);
    push(32'h0, 2'b10, 1'b0, t + 2);
    push(32'h100, 2'b00, 1'b1, t + 4);
    wait_done();

    exp_words = '{32'h0, 32'h0, 32'h0};
    ar_req(32'h0, 4'd2, 2'b10, t); push_burst(t, 2'b10); wait_done();

    exp_words = '{32'h0, 32'h0};
    ar_req(32'h8, 4'd1, 2'b11, t); push_burst(t, 2'b10); wait_done();

    // Load lands on the same edge as the FETCH of word 2: old data first, new data after.
    ar_req(32'h8, 4'd0, 2'b00, t);
    push(32'h102, 2'b00, 1'b1, t + 2);
    load(32'h8, 32'hDEAD_BEEF);
    wait_done();
    exp_words = '{32'hDEAD_BEEF};
    ar_req(32'h8, 4'd0, 2'b01, t); push_burst(t, 2'b00); wait_done();

    // Reset while beat 1 of a 4-beat burst is waiting.
    ar_req(32'h0, 4'd3, 2'b01, t);
    push(32'h100, 2'b00, 1'b0, t + 2);
    step();
    step();
    RREADY = 1'b0;
    step();
    chk("mid_rvalid_before_rst", 32'(RVALID), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(RVALID), 32'd0);
    chk("mid_rst_arready", 32'(ARREADY), 32'd1);
    chk("mid_rst_rlast", 32'(RLAST), 32'd0);
    chk("mid_rst_rdata", RDATA, 32'd0);
    step();
    rst = 1'b0;
    RREADY = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);
    exp_words = '{32'h101};
    ar_req(32'h4, 4'd0, 2'b01, t); push_burst(t, 2'b00); wait_done();

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_axi_read_slave.md
IMEM_AXI_READ_SLAVE -- requirements
Module: imem_axi_read_slave

Interface
REQ-001 Parameter MEM_WORDS, default 4096, depth of the 32-bit word array; power of two.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ARADDR  input  32  byte address of the first beat.
REQ-005 ARLEN  input  4  beats minus one (AXI3).
REQ-006 ARBURST  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-007 ARVALID  input  1  address valid from the instruction cache controller.
REQ-008 ARREADY  output  1  address accept.
REQ-009 RDATA  output  32  read beat data.
REQ-010 RRESP  output  2  00 OKAY, 10 SLVERR.
REQ-011 RLAST  output  1  final beat of the burst.
REQ-012 RVALID  output  1  beat valid.
REQ-013 RREADY  input  1  beat accept.
REQ-014 load_en / load_addr[31:0] / load_data[31:0]  input  backdoor word write for program preload.

Function
REQ-015 The FSM SHALL have three states: IDLE, FETCH, BEAT.
REQ-016 ARREADY SHALL be 1 only in IDLE; an AR handshake is ARVALID&ARREADY in the same cycle.
REQ-017 On an AR handshake in cycle T, the block SHALL latch ARADDR[31:2] as the word address, ARLEN and ARBURST, load beat_cnt=ARLEN, and enter FETCH at T+1.
REQ-018 FETCH SHALL perform a one-cycle synchronous array read of the current address and enter BEAT next cycle; RVALID SHALL rise at T+2 for beat 0.
REQ-019 In BEAT, RVALID=1 and RDATA/RRESP/RLAST SHALL hold stable until RREADY=1.
REQ-020 On R handshake with beat_cnt!=0: decrement beat_cnt, advance address, enter FETCH (RVALID=0 next cycle); each later beat therefore costs 2 cycles minimum.
REQ-021 On R handshake with beat_cnt==0 (RLAST=1): enter IDLE; ARREADY=1 next cycle.
REQ-022 RLAST SHALL equal (beat_cnt==0) while RVALID=1, and 0 otherwise.
REQ-023 Address advance: FIXED unchanged; INCR word+1, wraps modulo 2^30; WRAP with mask=ARLEN: next=(addr&~mask)|((addr+1)&mask).
REQ-024 WRAP with ARLEN not in {1,3,7,15}, or ARBURST=11, SHALL return ARLEN+1 beats with RRESP=10, RDATA=0.
REQ-025 A beat whose word address >= MEM_WORDS SHALL return RRESP=10, RDATA=0; other beats RRESP=00. Error is per beat; the burst length is never shortened.
REQ-026 ARADDR[1:0] SHALL be ignored (word aligned).
REQ-027 load_en=1 SHALL write load_data to word load_addr[31:2] at that edge in any state; out-of-range load ignored.
REQ-028 Load and FETCH to the same word in the same cycle: FETCH SHALL return the old data.
REQ-029 ARVALID in non-IDLE states SHALL be ignored (not accepted, no side effect).

Reset
REQ-030 rst=1 SHALL immediately force IDLE, ARREADY=1, RVALID=0, RLAST=0, RRESP=00, RDATA=0, beat_cnt=0, regardless of clock.
REQ-031 Reset mid-burst SHALL abandon the burst; no further beats after release.
REQ-032 Array contents SHALL NOT be cleared by reset.

Verification
REQ-033 Preload words 0..7 with 0x100+i; INCR ARADDR=0x0, ARLEN=3, RREADY=1 -> RDATA 0x100,0x101,0x102,0x103 on cycles T+2,T+4,T+6,T+8, RLAST only on 4th, RRESP=00.
REQ-034 WRAP ARADDR=0x18, ARLEN=3 -> words 6,7,4,5 (0x106,0x107,0x104,0x105), RLAST on 4th.
REQ-035 INCR ARADDR=0x0, ARLEN=1 with RREADY=0 for 5 cycles at beat 0 -> RVALID held 1, RDATA 0x100 stable, no address advance; beat 1 follows release by 2 cycles.
REQ-036 MEM_WORDS=4096, INCR ARADDR=0x3FFC, ARLEN=1 -> beat 0 RRESP=00 data word 4095, beat 1 RRESP=10 data 0, RLAST=1.
REQ-037 rst asserted at beat 1 of ARLEN=3 burst -> RVALID=0 and ARREADY=1 same cycle; after release a new ARLEN=0 read returns one beat with RLAST=1.
REQ-038 WRAP ARLEN=2 -> three beats, RRESP=10, RDATA=0.
